// File: rtl/chaos_keystream_xor.sv
// Quantizes chaotic-map float samples to key bytes and XORs them with pixel
// bytes under CBC-style chaining (encrypt or decrypt), one byte per sample.
module chaos_keystream_xor #(
    parameter int          KEY_SHIFT = 8,
    parameter logic [7:0]  IV        = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        decrypt,
    input  logic        frame_start,
    input  logic [31:0] chaos_data,
    input  logic        chaos_valid,
    output logic        chaos_ready,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pix_count,
    output logic        err_flag
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_SHIFT,
        S_OUTPUT
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [30:0]        r_chaos;
    logic [7:0]         r_pix;
    logic               r_dec;
    logic [23:0]        r_m;
    logic signed [9:0]  r_s;
    logic               r_kzero;
    logic [7:0]         r_out_data;
    logic               r_out_valid;
    logic [7:0]         r_chain;
    logic [15:0]        r_count;
    logic               r_err;

    logic               w_accept;
    logic               w_hs;
    logic [7:0]         w_exp;
    logic signed [9:0]  w_s;
    logic [9:0]         w_neg;
    logic [7:0]         w_key;
    logic [7:0]         w_chain;

    // Both channels are consumed together or not at all.
    assign w_accept    = (r_state == S_IDLE) & chaos_valid & pix_valid & ~reset;
    assign chaos_ready = w_accept;
    assign pix_ready   = w_accept;

    assign w_hs    = r_out_valid & out_ready;
    assign w_exp   = r_chaos[30:23];
    assign w_s     = $signed({2'b00, w_exp}) + $signed(10'(KEY_SHIFT - 150));
    assign w_chain = frame_start ? IV : r_chain;

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign pix_count = r_count;
    assign err_flag  = r_err;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DECODE;
            S_DECODE: w_next = S_SHIFT;
            S_SHIFT:  w_next = S_OUTPUT;
            S_OUTPUT: if (w_hs) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Integer part of |v| * 2^KEY_SHIFT, keeping only the low byte.
    always_comb begin
        w_key = '0;
        w_neg = 10'(-r_s);
        if (!r_kzero) begin
            if (!r_s[9]) begin
                if (r_s < 10'sd8) w_key = r_m[7:0] << r_s[2:0];
            end else if (w_neg <= 10'd23) begin
                w_key = 8'(r_m >> w_neg[4:0]);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_chaos     <= '0;
            r_pix       <= '0;
            r_dec       <= 1'b0;
            r_m         <= '0;
            r_s         <= '0;
            r_kzero     <= 1'b0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_chain     <= IV;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_chaos <= chaos_data[30:0];
                r_pix   <= pix_data;
                r_dec   <= decrypt;
            end
            if (r_state == S_DECODE) begin
                r_m     <= {1'b1, r_chaos[22:0]};
                r_s     <= w_s;
                r_kzero <= (w_exp == 8'h00) | (w_exp == 8'hFF);
            end
            if (r_state == S_SHIFT) begin
                r_out_data  <= r_pix ^ w_key ^ w_chain;
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
            // frame_start outranks the chaining update of a delivered byte.
            if (frame_start) begin
                r_chain <= IV;
                r_count <= '0;
            end else if (w_hs) begin
                r_chain <= r_dec ? r_pix : r_out_data;
                r_count <= r_count + 16'd1;
            end
            if (frame_start)
                r_err <= 1'b0;
            else if ((r_state == S_DECODE) && (w_exp == 8'hFF))
                r_err <= 1'b1;
        end
    end

endmodule
